transfer_request_queue: RTL
===========================

# transfer_request_queue

Synthesizable, parametrised transfer-request generator for the ADMA engine. It replaces fixed stimulus sequences with a small command queue. Software or bench logic pushes (direction, length, address) commands. The block issues each command to the transfer engine as a one-cycle `start` pulse with stable qualifiers, waits for `transfer_done`, then enforces a programmable idle gap before issuing the next command. It sits between the command source and the ADMA transfer datapath.

## Interface
- `ADDR_WIDTH`, 64: width of `push_address` / `address_init`.
- `LEN_WIDTH`, 16: width of `push_length` / `length`.
- `DEPTH`, 4: command queue depth; power of two, ≥2.
- `GAP_CYCLES`, 8: idle cycles between `transfer_done` and the next issue; 0 allowed.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `push` in 1: enqueue request.
- `push_direction` in 1: 1 = RAM→FIFO, 0 = FIFO→RAM.
- `push_length` in LEN_WIDTH: transfer length; 0 is illegal.
- `push_address` in ADDR_WIDTH: initial address.
- `flush` in 1: discard all queued, not-yet-issued commands.
- `transfer_done` in 1: one-cycle completion pulse from the engine.
- `start` out 1: one-cycle issue pulse.
- `direction` out 1: qualifier of the current/last issued command.
- `length` out LEN_WIDTH: qualifier of the current/last issued command.
- `address_init` out ADDR_WIDTH: qualifier of the current/last issued command.
- `busy` out 1: FSM not in IDLE.
- `full` out 1: queue holds DEPTH entries.
- `count` out $clog2(DEPTH+1): number of queued entries.
- `overflow` out 1: sticky; a push was rejected because the queue was full.
- `bad_len` out 1: sticky; a push was rejected because `push_length`=0.

## Operation
- The queue is a FIFO; `push` is accepted iff `!full && push_length!=0 && !flush`.
- Rejected pushes leave the queue unchanged and set the matching sticky flag.
- Sticky flags clear only on `RESET`.
- FSM states:
  - IDLE: if `count!=0`, go to ISSUE.
  - ISSUE: pop the head entry, load `direction`/`length`/`address_init`, assert `start`=1 for this single cycle, go to WAIT_DONE.
  - WAIT_DONE: on `transfer_done`, go to GAP, or directly to IDLE when GAP_CYCLES=0.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Qualifiers are held stable from ISSUE until the next ISSUE.
- `transfer_done` is ignored outside WAIT_DONE.
- `flush` empties the queue in one cycle. It does not abort an in-flight transfer; the FSM still waits for `transfer_done`.
- `flush` and `push` in the same cycle: flush wins, and the push is dropped without setting a flag.
- Push and pop in the same cycle with `count<DEPTH`: both take effect, and `count` is unchanged.
- Push while `full`: rejected even if a pop occurs in the same cycle.
- Reset values: `start`=0, `direction`=1, `length`=0, `address_init`=0, `busy`=0, `full`=0, `count`=0, `overflow`=0, `bad_len`=0; FSM in IDLE.
- `RESET` mid-transfer: all state is cleared immediately, and any later `transfer_done` is ignored.
- Read/write pointers wrap modulo DEPTH; `count` is the occupancy, not a pointer difference.

## Timing
- All outputs are registered.
- Push accepted at edge t into an empty queue with FSM in IDLE:
  - `count`=1 after edge t.
  - ISSUE entered at edge t+1.
  - `start`=1 and qualifiers valid for the cycle after edge t+1; `start` deasserts at edge t+2.
- `transfer_done` sampled at edge d:
  - GAP_CYCLES=N>0: next `start` (if queued) after edge d+N+2.
  - GAP_CYCLES=0: next `start` after edge d+2.
- `full` and `count` update on the same edge as the accepted push or pop.

## Structure
- Shared package `adma_pkg`:
  - `DIR_RAM_TO_FIFO`=1 and `DIR_FIFO_TO_RAM`=0.
  - FSM state typedef (IDLE, ISSUE, WAIT_DONE, GAP).
  - Command struct {direction, length, address}, parametrised through widths.
- One sub-module, `transfer_cmd_fifo`: a DEPTH-entry synchronous FIFO with push, pop, flush, full, empty and count.
- FSM and gap counter live in the top module.

## Test plan
- Reset, then idle 5 cycles → all outputs at reset values; `start` never pulses.
- Push (dir=1, len=6, addr=0) → `start` pulse one cycle, two edges after the push; `length`=6, `address_init`=0, `direction`=1. After `transfer_done`, `busy` drops 9 cycles later (GAP_CYCLES=8).
- Push 4 commands back-to-back, then a 5th (DEPTH=4) → 5th rejected and `overflow`=1. The 4 starts issue in order, each spaced by done + gap.
- Push with len=0 → `bad_len`=1 and `count` unchanged. A following push (dir=0, len=5, addr=12) issues normally with `direction`=0.
- Two queued commands, `flush` during WAIT_DONE → `count`=0. The in-flight transfer completes, and no further `start` is issued.
- `RESET` asserted in GAP with 2 queued → next cycle `count`=0, `busy`=0, qualifiers zeroed (`direction`=1), no `start`.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared ADMA definitions: direction encodings, request-queue FSM states and the
// queued command payload.
package adma_pkg;

  localparam logic DIR_RAM_TO_FIFO = 1'b1;
  localparam logic DIR_FIFO_TO_RAM = 1'b0;

  localparam int unsigned CMD_ADDR_WIDTH = 64;
  localparam int unsigned CMD_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } rq_state_t;

  typedef struct packed {
    logic                      direction;
    logic [CMD_LEN_WIDTH-1:0]  length;
    logic [CMD_ADDR_WIDTH-1:0] address;
  } cmd_t;

endpackage

// File: rtl/transfer_request_queue_if.sv
// Command-source / transfer-engine bundle for the transfer request queue.
interface transfer_request_queue_if #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

  logic                  push;
  logic                  push_direction;
  logic [LEN_WIDTH-1:0]  push_length;
  logic [ADDR_WIDTH-1:0] push_address;
  logic                  flush;
  logic                  transfer_done;
  logic                  start;
  logic                  direction;
  logic [LEN_WIDTH-1:0]  length;
  logic [ADDR_WIDTH-1:0] address_init;
  logic                  busy;
  logic                  full;
  logic [COUNT_W-1:0]    count;
  logic                  overflow;
  logic                  bad_len;

  modport master (
    output push, push_direction, push_length, push_address, flush, transfer_done,
    input  start, direction, length, address_init, busy, full, count, overflow, bad_len
  );

  modport slave (
    input  push, push_direction, push_length, push_address, flush, transfer_done,
    output start, direction, length, address_init, busy, full, count, overflow, bad_len
  );

endinterface

// File: rtl/transfer_request_queue_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with single-cycle flush and registered
// occupancy/full/empty status.
module transfer_cmd_fifo
  import adma_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  cmd_t                         wdata,
  output cmd_t                         rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Full is judged on the pre-pop occupancy, so a push into a full queue is lost
  assign do_push_c = push && !full && !flush;
  assign do_pop_c  = pop && !empty && !flush;

  always_comb begin
    count_nxt_c = count;
    if (flush) begin
      count_nxt_c = '0;
    end else begin
      count_nxt_c = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/transfer_request_queue.sv
// Queued transfer-request generator: issues each command as a one-cycle start
// pulse, waits for completion, then holds off for GAP_CYCLES before the next.
module transfer_request_queue
  import adma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  transfer_request_queue_if.slave    bus
);

  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  rq_state_t            state;
  logic                 start;
  logic                 direction;
  logic [LEN_WIDTH-1:0] length;
  logic [ADDR_WIDTH-1:0] address_init;
  logic                 busy;
  logic                 overflow;
  logic                 bad_len;
  logic                 done_q;
  logic [GAP_W-1:0]     gap_cnt;

  cmd_t                 cmd_in_c;
  cmd_t                 head;
  logic                 push_live_c;
  logic                 len_zero_c;
  logic                 push_ok_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [COUNT_W-1:0]   fifo_count;

  assign len_zero_c  = (bus.push_length == '0);
  assign push_live_c = bus.push && !bus.flush;
  assign push_ok_c   = push_live_c && !fifo_full && !len_zero_c;

  assign cmd_in_c.direction = bus.push_direction;
  assign cmd_in_c.length    = CMD_LEN_WIDTH'(bus.push_length);
  assign cmd_in_c.address   = CMD_ADDR_WIDTH'(bus.push_address);

  transfer_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push_ok_c),
    .pop   (state == ST_ISSUE),
    .flush (bus.flush),
    .wdata (cmd_in_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Completion is only accepted while a transfer is outstanding
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      start        <= 1'b0;
      direction    <= DIR_RAM_TO_FIFO;
      length       <= '0;
      address_init <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      bad_len      <= 1'b0;
      done_q       <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      start  <= 1'b0;
      done_q <= bus.transfer_done && (state == ST_WAIT_DONE);
      if (push_live_c && fifo_full) overflow <= 1'b1;
      if (push_live_c && len_zero_c) bad_len <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state        <= ST_ISSUE;
            start        <= 1'b1;
            busy         <= 1'b1;
            direction    <= head.direction;
            length       <= LEN_WIDTH'(head.length);
            address_init <= ADDR_WIDTH'(head.address);
          end
        end
        ST_ISSUE: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (done_q) begin
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start        = start;
  assign bus.direction    = direction;
  assign bus.length       = length;
  assign bus.address_init = address_init;
  assign bus.busy         = busy;
  assign bus.full         = fifo_full;
  assign bus.count        = fifo_count;
  assign bus.overflow     = overflow;
  assign bus.bad_len      = bad_len;

endmodule
